// File: rtl/stk_pipe_mem_head_ctrl_if.sv
// Request/response and SRAM bus bundle for the stack-pipe head-pointer SRAM controller.
// slave = controller side, master = requester/memory environment side.
interface stk_pipe_mem_head_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
);
    logic              i_rd_vld;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_rdy;
    logic              o_rd_rsp_vld;
    logic [DATA_W-1:0] o_rd_rsp_data;
    logic              i_wr_vld;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_rdy;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_din;
    logic              o_sram_ce;
    logic              o_sram_oe;
    logic [DATA_W-1:0] i_sram_dout;

    modport slave (
        input  i_rd_vld, i_rd_addr, i_wr_vld, i_wr_addr, i_wr_data, i_sram_dout,
        output o_rd_rdy, o_rd_rsp_vld, o_rd_rsp_data, o_wr_rdy,
        output o_sram_addr, o_sram_din, o_sram_ce, o_sram_oe
    );

    modport master (
        output i_rd_vld, i_rd_addr, i_wr_vld, i_wr_addr, i_wr_data, i_sram_dout,
        input  o_rd_rdy, o_rd_rsp_vld, o_rd_rsp_data, o_wr_rdy,
        input  o_sram_addr, o_sram_din, o_sram_ce, o_sram_oe
    );
endinterface

// File: rtl/stk_pipe_mem_head_ctrl.sv
// Head-pointer SRAM controller: optional post-reset init sweep (STK_PIPE_MEM_HEAD_CTRL_INIT_EN), then write-priority arbitration.
// Latency: grants are combinational; read response 1 cycle after grant. Backpressure: rdy low while sweeping or losing arbitration.
// A read waiting behind STARVE_MAX consecutive write grants is forced through on the next cycle.
module stk_pipe_mem_head_ctrl #(
    parameter int                N          = 1024,
    parameter int                ADDR_W     = 10,
    parameter int                DATA_W     = 10,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0,
    parameter int                STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    stk_pipe_mem_head_ctrl_if.slave       bus,
    output logic                          o_init_busy
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_nxt;
    logic        r_rsp_vld;
    logic        w_force_rd;
    logic        w_wr_gnt;
    logic        w_rd_gnt;

`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
    logic [ADDR_W-1:0] r_sweep_cnt;
    logic [ADDR_W-1:0] w_sweep_nxt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_INIT;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_sweep_nxt;
        end
    end

    assign o_init_busy = (r_state == S_INIT);
`else
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_init_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_starve_cnt <= '0;
            r_rsp_vld    <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_rsp_vld    <= w_rd_gnt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
        w_sweep_nxt     = r_sweep_cnt;
`endif
        w_wr_gnt        = 1'b0;
        w_rd_gnt        = 1'b0;
        bus.o_sram_ce   = 1'b0;
        bus.o_sram_oe   = 1'b0;
        bus.o_sram_addr = '0;
        bus.o_sram_din  = '0;
        w_force_rd      = bus.i_rd_vld && (r_starve_cnt == STARVE_LIM);

        case (r_state)
            S_INIT: begin
`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
                bus.o_sram_ce   = 1'b1;
                bus.o_sram_addr = r_sweep_cnt;
                bus.o_sram_din  = INIT_VAL;
                w_sweep_nxt     = r_sweep_cnt + 1'b1;
                if (r_sweep_cnt == LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                end
`endif
            end
            S_RUN: begin
                if (bus.i_wr_vld && !w_force_rd) begin
                    w_wr_gnt        = 1'b1;
                    bus.o_sram_ce   = 1'b1;
                    bus.o_sram_addr = bus.i_wr_addr;
                    bus.o_sram_din  = bus.i_wr_data;
                end else if (bus.i_rd_vld) begin
                    w_rd_gnt        = 1'b1;
                    bus.o_sram_ce   = 1'b1;
                    bus.o_sram_oe   = 1'b1;
                    bus.o_sram_addr = bus.i_rd_addr;
                end
            end
            default: ;
        endcase

        // The SRAM stays idle and nothing is granted while reset is held.
        if (!arst_n) begin
            w_wr_gnt      = 1'b0;
            w_rd_gnt      = 1'b0;
            bus.o_sram_ce = 1'b0;
        end

        if (!bus.i_rd_vld || w_rd_gnt) begin
            w_starve_nxt = '0;
        end else if (w_wr_gnt && (r_starve_cnt != STARVE_LIM)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    assign bus.o_rd_rdy      = w_rd_gnt;
    assign bus.o_wr_rdy      = w_wr_gnt;
    assign bus.o_rd_rsp_vld  = r_rsp_vld;
    assign bus.o_rd_rsp_data = bus.i_sram_dout;
endmodule

// File: tb/tb_stk_pipe_mem_head_ctrl.sv
// Directed bench for stk_pipe_mem_head_ctrl with an SRAM model and a read-response scoreboard.
// Covers STK_PIPE_MEM_HEAD_CTRL_INIT_EN builds with and without the init sweep.
module tb_stk_pipe_mem_head_ctrl;
    localparam int          N    = 1024;
    localparam int          AW   = 10;
    localparam int          DW   = 10;
    localparam logic [9:0]  INIT = 10'h155;
`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
    localparam logic [9:0]  PRE_VAL   = 10'h0AA;
    localparam logic [31:0] EXP_BUSY0 = 32'd1;
`else
    localparam logic [9:0]  PRE_VAL   = INIT;
    localparam logic [31:0] EXP_BUSY0 = 32'd0;
`endif

    logic clk;
    logic arst_n;
    logic init_busy;
    logic preload;

    stk_pipe_mem_head_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    stk_pipe_mem_head_ctrl #(
        .N(N), .ADDR_W(AW), .DATA_W(DW), .INIT_VAL(INIT), .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .bus(bus),
        .o_init_busy(init_busy)
    );

    logic [DW-1:0] mem [N];
    logic [DW-1:0] ref_mem [N];
    int            init_hits [N];
    int            init_badval;
    logic [DW-1:0] exp_q [$];
    int            errors = 0;
    int            checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < N; i++) mem[i] <= PRE_VAL;
        end else if (bus.o_sram_ce) begin
            if (bus.o_sram_oe) bus.i_sram_dout <= mem[bus.o_sram_addr];
            else               mem[bus.o_sram_addr] <= bus.o_sram_din;
        end
    end

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < N; i++) init_hits[i] <= 0;
            init_badval <= 0;
        end else if (init_busy && bus.o_sram_ce && !bus.o_sram_oe) begin
            init_hits[bus.o_sram_addr] <= init_hits[bus.o_sram_addr] + 1;
            if (bus.o_sram_din !== INIT) init_badval <= init_badval + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request cycle: drive, check grants, then check the response after the edge.
    task automatic cyc(input logic rv, input logic [AW-1:0] ra, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic erd, input logic ewr, input string tag);
        logic pend;
        bus.i_rd_vld  = rv;
        bus.i_rd_addr = ra;
        bus.i_wr_vld  = wv;
        bus.i_wr_addr = wa;
        bus.i_wr_data = wd;
        #1;
        chk({tag, "_rrdy"}, 32'(bus.o_rd_rdy), 32'(erd));
        chk({tag, "_wrdy"}, 32'(bus.o_wr_rdy), 32'(ewr));
        chk({tag, "_ce"}, 32'(bus.o_sram_ce), 32'(erd | ewr));
        if (ewr) ref_mem[wa] = wd;
        if (erd) exp_q.push_back(ref_mem[ra]);
        pend = erd;
        @(posedge clk);
        #1;
        chk({tag, "_rspv"}, 32'(bus.o_rd_rsp_vld), 32'(pend));
        if (bus.o_rd_rsp_vld && exp_q.size() != 0)
            chk({tag, "_rspd"}, 32'(bus.o_rd_rsp_data), 32'(exp_q.pop_front()));
    endtask

`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
    task automatic sweep_check(input string tag);
        int n;
        int bad;
        logic any_rdy;
        n = 0;
        any_rdy = 1'b0;
        while (init_busy && n < 2000) begin
            if (bus.o_rd_rdy || bus.o_wr_rdy) any_rdy = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        bad = init_badval;
        for (int i = 0; i < N; i++) if (init_hits[i] != 1) bad++;
        chk({tag, "_len"}, 32'(n), 32'(N));
        chk({tag, "_no_rdy"}, 32'(any_rdy), 32'd0);
        chk({tag, "_cover"}, 32'(bad), 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) ref_mem[i] = INIT;
        arst_n        = 1'b0;
        preload       = 1'b1;
        bus.i_rd_vld  = 1'b1;
        bus.i_rd_addr = 10'h3FF;
        bus.i_wr_vld  = 1'b1;
        bus.i_wr_addr = 10'h010;
        bus.i_wr_data = 10'h2A5;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        chk("rst_busy", 32'(init_busy), EXP_BUSY0);
        chk("rst_rrdy", 32'(bus.o_rd_rdy), 32'd0);
        chk("rst_wrdy", 32'(bus.o_wr_rdy), 32'd0);
        chk("rst_rspv", 32'(bus.o_rd_rsp_vld), 32'd0);
        chk("rst_ce", 32'(bus.o_sram_ce), 32'd0);
        arst_n = 1'b1;
`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
        sweep_check("init");
`endif
        // Write and read-back, including the address written last by the sweep.
        cyc(1, 10'h3FF, 1, 10'h010, 10'h2A5, 0, 1, "wr010");
        cyc(1, 10'h3FF, 0, 10'h000, 10'h000, 1, 0, "rd3ff");
        cyc(1, 10'h010, 0, 10'h000, 10'h000, 1, 0, "rd010");
        cyc(1, 10'h020, 1, 10'h020, 10'h111, 0, 1, "same_wr");
        cyc(1, 10'h020, 0, 10'h000, 10'h000, 1, 0, "same_rd");
        cyc(0, 10'h000, 0, 10'h000, 10'h000, 0, 0, "idle");

        // Starvation: four writes, forced read (old data), held write, four writes, read (new data).
        cyc(1, 10'h030, 1, 10'h041, 10'h001, 0, 1, "stv_w0");
        cyc(1, 10'h030, 1, 10'h042, 10'h002, 0, 1, "stv_w1");
        cyc(1, 10'h030, 1, 10'h043, 10'h003, 0, 1, "stv_w2");
        cyc(1, 10'h030, 1, 10'h044, 10'h004, 0, 1, "stv_w3");
        cyc(1, 10'h030, 1, 10'h030, 10'h3CC, 1, 0, "stv_force");
        cyc(1, 10'h030, 1, 10'h030, 10'h3CC, 0, 1, "stv_held");
        cyc(1, 10'h030, 1, 10'h045, 10'h005, 0, 1, "stv_w5");
        cyc(1, 10'h030, 1, 10'h046, 10'h006, 0, 1, "stv_w6");
        cyc(1, 10'h030, 1, 10'h047, 10'h007, 0, 1, "stv_w7");
        cyc(1, 10'h030, 1, 10'h048, 10'h008, 1, 0, "stv_force2");
        cyc(0, 10'h000, 1, 10'h048, 10'h008, 0, 1, "stv_drop");

        for (int i = 1; i <= 8; i++)
            cyc(0, 10'h000, 1, AW'(i), DW'(10'h100 + i), 0, 1, "b2b_fill");
        for (int i = 1; i <= 8; i++)
            cyc(1, AW'(i), 0, 10'h000, 10'h000, 1, 0, "b2b_rd");

        // Reset with a response in flight.
        bus.i_rd_vld  = 1'b1;
        bus.i_rd_addr = 10'h010;
        bus.i_wr_vld  = 1'b0;
        #1;
        chk("pend_rrdy", 32'(bus.o_rd_rdy), 32'd1);
        @(posedge clk);
        #1;
        chk("pend_rspv_pre", 32'(bus.o_rd_rsp_vld), 32'd1);
        arst_n       = 1'b0;
        bus.i_rd_vld = 1'b0;
        #1;
        chk("pend_rspv_rst", 32'(bus.o_rd_rsp_vld), 32'd0);
        chk("pend_busy", 32'(init_busy), EXP_BUSY0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
`ifdef STK_PIPE_MEM_HEAD_CTRL_INIT_EN
        sweep_check("resweep1");
        // Reset again partway through the sweep, at counter 0x200.
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (10'h200) @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(init_busy), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(init_busy), 32'd1);
        chk("mid_ce", 32'(bus.o_sram_ce), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        sweep_check("resweep2");
        for (int i = 0; i < N; i++) ref_mem[i] = INIT;
`endif
        cyc(1, 10'h010, 0, 10'h000, 10'h000, 1, 0, "post_rd010");
        cyc(1, 10'h030, 0, 10'h000, 10'h000, 1, 0, "post_rd030");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
